// File: rtl/fe2de_ibuf.sv
// rtl/fe2de_ibuf.sv - fetch-to-decode instruction queue
//
// Purpose: in-order queue of fetched instructions between fetch and decode.
//   Decode stalls are absorbed here, and fetch is held off while the queue is full.
//   Reads are first-word fall-through from storage. There is no same-cycle bypass.
//   A redirect (fet_flush) empties the queue in one cycle.
//
// Ports:
//   clk, cpurst          - core clock, synchronous active-high reset
//   fet_valid            - fetch presents an instruction this cycle
//   rv32_instr_todec     - expanded 32-bit instruction
//   fetch_pc             - PC of that instruction
//   fe2de_rv16           - instruction was compressed
//   predict_bxxtaken     - fetch predicted taken
//   fet_flush            - redirect: drop queued and incoming entries
//   dec_stall            - decode cannot accept this cycle
//   fet_stall            - queue full, fetch must hold
//   de_valid             - head entry valid for decode
//   de_instr/de_pc/de_rv16/de_predict_taken - head entry payload
//   ibuf_count           - registered occupancy, 0..DEPTH

module fe2de_ibuf #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic            clk,
  input  logic            cpurst,
  input  logic            fet_valid,
  input  logic [31:0]     rv32_instr_todec,
  input  logic [31:0]     fetch_pc,
  input  logic            fe2de_rv16,
  input  logic            predict_bxxtaken,
  input  logic            fet_flush,
  input  logic            dec_stall,
  output logic            fet_stall,
  output logic            de_valid,
  output logic [31:0]     de_instr,
  output logic [31:0]     de_pc,
  output logic            de_rv16,
  output logic            de_predict_taken,
  output logic [PTRW:0]   ibuf_count
);

  localparam logic [31:0]   NOP_INSTR = 32'h0000_0013;
  localparam logic [PTRW:0] FULL_CNT  = (PTRW+1)'(DEPTH);

  // Entry layout: {instr[65:34], pc[33:2], rv16[1], ptaken[0]}
  localparam int EW = 66;

  logic [EW-1:0]   mem_q [DEPTH];
  logic [PTRW-1:0] wptr_q, wptr_d;
  logic [PTRW-1:0] rptr_q, rptr_d;
  logic [PTRW:0]   cnt_q, cnt_d;

  logic full, empty, push, pop;
  logic [EW-1:0] head;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

  // Push is gated by full alone, not by a same-cycle pop. This keeps
  // dec_stall out of the fetch-side accept path.
  assign push = fet_valid & ~full & ~fet_flush;
  assign pop  = de_valid & ~dec_stall;

  assign fet_stall  = full;
  assign de_valid   = ~empty & ~fet_flush;
  assign ibuf_count = cnt_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (fet_flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      // Pointers wrap modulo DEPTH by natural overflow.
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      cnt_d = cnt_q + {{PTRW{1'b0}}, push} - {{PTRW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (cpurst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload storage is not reset. Valid tracking is done entirely by cnt.
  always_ff @(posedge clk) begin
    if (push && !cpurst) begin
      mem_q[wptr_q] <= {rv32_instr_todec, fetch_pc, fe2de_rv16, predict_bxxtaken};
    end
  end

  assign head = mem_q[rptr_q];

  // Payload is squashed to a NOP/zero bundle whenever the head is not valid.
  // Decode therefore never latches a stale entry or an uninitialised one.
  always_comb begin
    de_instr         = NOP_INSTR;
    de_pc            = '0;
    de_rv16          = 1'b0;
    de_predict_taken = 1'b0;
    if (de_valid) begin
      de_instr         = head[65:34];
      de_pc            = head[33:2];
      de_rv16          = head[1];
      de_predict_taken = head[0];
    end
  end

endmodule

// File: tb/tb_fe2de_ibuf.sv
// tb/tb_fe2de_ibuf.sv - directed self-checking bench for fe2de_ibuf

module tb_fe2de_ibuf;

  logic        clk = 1'b0;
  logic        cpurst;
  logic        fet_valid;
  logic [31:0] rv32_instr_todec;
  logic [31:0] fetch_pc;
  logic        fe2de_rv16;
  logic        predict_bxxtaken;
  logic        fet_flush;
  logic        dec_stall;
  logic        fet_stall;
  logic        de_valid;
  logic [31:0] de_instr;
  logic [31:0] de_pc;
  logic        de_rv16;
  logic        de_predict_taken;
  logic [2:0]  ibuf_count;

  int n_checks = 0;
  int n_fail   = 0;

  fe2de_ibuf #(.DEPTH(4), .PTRW(2)) dut (
    .clk              (clk),
    .cpurst           (cpurst),
    .fet_valid        (fet_valid),
    .rv32_instr_todec (rv32_instr_todec),
    .fetch_pc         (fetch_pc),
    .fe2de_rv16       (fe2de_rv16),
    .predict_bxxtaken (predict_bxxtaken),
    .fet_flush        (fet_flush),
    .dec_stall        (dec_stall),
    .fet_stall        (fet_stall),
    .de_valid         (de_valid),
    .de_instr         (de_instr),
    .de_pc            (de_pc),
    .de_rv16          (de_rv16),
    .de_predict_taken (de_predict_taken),
    .ibuf_count       (ibuf_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then let inputs/outputs settle away from the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic r16, input logic pt);
    fet_valid        = v;
    rv32_instr_todec = ins;
    fetch_pc         = pc;
    fe2de_rv16       = r16;
    predict_bxxtaken = pt;
  endtask

  logic [31:0] exp_instr, exp_pc;

  initial begin
    cpurst    = 1'b1;
    fet_flush = 1'b0;
    dec_stall = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Reset then idle
    tick; tick;
    cpurst = 1'b0;
    #1;
    check_eq("rst_de_valid",  de_valid,   0);
    check_eq("rst_de_instr",  de_instr,   32'h0000_0013);
    check_eq("rst_de_pc",     de_pc,      0);
    check_eq("rst_fet_stall", fet_stall,  0);
    check_eq("rst_count",     ibuf_count, 0);
    tick;
    check_eq("idle_de_valid", de_valid,   0);

    // Single push latency
    drive(1'b1, 32'h0050_0093, 32'h8000_0000, 1'b0, 1'b0);
    #1;
    check_eq("single_no_bypass", de_valid, 0);
    tick;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check_eq("single_de_valid", de_valid,   1);
    check_eq("single_de_instr", de_instr,   32'h0050_0093);
    check_eq("single_de_pc",    de_pc,      32'h8000_0000);
    check_eq("single_count",    ibuf_count, 1);
    tick;
    check_eq("single_count_after_pop", ibuf_count, 0);
    check_eq("single_valid_after_pop", de_valid,   0);

    // Fill and backpressure
    dec_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h11 * (i + 1), 32'h100 + 4 * i, 1'b0, 1'b0);
      tick;
    end
    check_eq("fill_count",     ibuf_count, 4);
    check_eq("fill_fet_stall", fet_stall,  1);
    drive(1'b1, 32'h55, 32'h110, 1'b0, 1'b0);
    tick;
    check_eq("fill_5th_rejected", ibuf_count, 4);
    // Release decode while fetch still offers 0x55: the push is blocked this cycle.
    dec_stall = 1'b0;
    #1;
    check_eq("drain0_instr", de_instr,  32'h11);
    check_eq("drain0_pc",    de_pc,     32'h100);
    check_eq("drain0_stall", fet_stall, 1);
    tick;
    check_eq("drain1_count", ibuf_count, 3);
    check_eq("drain1_instr", de_instr,   32'h22);
    check_eq("drain1_stall", fet_stall,  0);
    tick;  // 0x55 accepted with pop of 0x22
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check_eq("drain2_count", ibuf_count, 3);
    check_eq("drain2_instr", de_instr,   32'h33);
    tick;
    check_eq("drain3_instr", de_instr,   32'h44);
    check_eq("drain3_pc",    de_pc,      32'h10C);
    tick;
    check_eq("drain4_instr", de_instr,   32'h55);
    check_eq("drain4_count", ibuf_count, 1);
    tick;
    check_eq("drain_empty_count", ibuf_count, 0);
    check_eq("drain_empty_valid", de_valid,   0);

    // Wrap-around: entry k carries instr 0x1000+k, pc 0x2000+2k, rv16=k[0], ptaken=k[1]
    for (int k = 0; k <= 10; k++) begin
      if (k < 10)
        drive(1'b1, 32'h1000 + k, 32'h2000 + 2 * k, k[0], k[1]);
      else
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      if (k > 0) begin
        check_eq($sformatf("wrap%0d_instr", k), de_instr, 32'h1000 + (k - 1));
        check_eq($sformatf("wrap%0d_pc", k),    de_pc,    32'h2000 + 2 * (k - 1));
        check_eq($sformatf("wrap%0d_rv16", k),  de_rv16,  (k - 1) & 1);
        check_eq($sformatf("wrap%0d_pt", k),    de_predict_taken, ((k - 1) >> 1) & 1);
        check_eq($sformatf("wrap%0d_count", k), ibuf_count, 1);
      end
      tick;
    end
    check_eq("wrap_final_count", ibuf_count, 0);

    // Flush with simultaneous push and pop
    dec_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hA1 + i, 32'h300 + 4 * i, 1'b0, 1'b0);
      tick;
    end
    check_eq("pre_flush_count", ibuf_count, 3);
    dec_stall = 1'b0;
    fet_flush = 1'b1;
    drive(1'b1, 32'hBB, 32'h400, 1'b1, 1'b1);
    #1;
    check_eq("flush_de_valid", de_valid, 0);
    check_eq("flush_de_instr", de_instr, 32'h0000_0013);
    tick;
    fet_flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check_eq("post_flush_count", ibuf_count, 0);
    check_eq("post_flush_valid", de_valid,   0);
    drive(1'b1, 32'hCC, 32'h8000_0040, 1'b0, 1'b1);
    tick;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check_eq("after_flush_valid", de_valid,   1);
    check_eq("after_flush_pc",    de_pc,      32'h8000_0040);
    check_eq("after_flush_instr", de_instr,   32'hCC);
    check_eq("after_flush_pt",    de_predict_taken, 1);
    check_eq("after_flush_count", ibuf_count, 1);
    tick;
    check_eq("after_flush_drained", ibuf_count, 0);

    // Multi-cycle flush keeps queue empty
    fet_flush = 1'b1;
    drive(1'b1, 32'hDD, 32'h500, 1'b0, 1'b0);
    tick;
    check_eq("mflush1_count", ibuf_count, 0);
    tick;
    check_eq("mflush2_count", ibuf_count, 0);
    fet_flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Reset priority
    dec_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'hE0 + i, 32'h600 + 4 * i, 1'b0, 1'b0);
      tick;
    end
    check_eq("pre_rst_count", ibuf_count, 2);
    cpurst = 1'b1;
    drive(1'b1, 32'hEF, 32'h700, 1'b0, 1'b0);
    tick;
    cpurst    = 1'b0;
    dec_stall = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check_eq("rstpri_count",     ibuf_count, 0);
    check_eq("rstpri_de_valid",  de_valid,   0);
    check_eq("rstpri_fet_stall", fet_stall,  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
